// File: rtl/mem_access_seq_if.sv
// ---------------------------------------------------------------------------
// mem_access_seq_if
//
// Purpose:
//   Bundles the request/response handshake between the CPU control FSM and
//   the memory-access sequencer, together with the memory-port signals the
//   sequencer drives. This keeps the sequencer's port list to clk, rst_n and
//   one interface.
//
// Signal summary:
//   Request side : req_valid, req_ready, req_write, req_byte, req_sext,
//                  req_indirect, req_addr, req_wdata
//   Response side: rsp_valid, rsp_rdata, rsp_error, busy
//   Memory side  : mem_address, mem_rdata, mem_wdata, mem_read, mem_write,
//                  mem_byte_enable, mem_resp
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding environment (control FSM plus memory)
// ---------------------------------------------------------------------------
interface mem_access_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);

    // Request from the control FSM
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic                    req_byte;
    logic                    req_sext;
    logic                    req_indirect;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // Response back to the control FSM
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_error;
    logic                    busy;

    // Memory port
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [DATA_WIDTH/8-1:0] mem_byte_enable;
    logic                    mem_resp;

    modport slave (
        input  req_valid, req_write, req_byte, req_sext, req_indirect,
               req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable
    );

    modport master (
        output req_valid, req_write, req_byte, req_sext, req_indirect,
               req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable
    );

endinterface

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
//
// Purpose:
//   Memory-access sequencer sitting between the multicycle CPU control FSM
//   and the memory port. It accepts one request at a time (load/store,
//   word/byte, direct/indirect), performs the optional pointer fetch, drives
//   the memory strobes with word-aligned addresses and byte lanes, enforces a
//   wait-state timeout and returns exactly one response per request.
//
// Parameters:
//   DATA_WIDTH     - word width in bits, multiple of 8 and >= 16
//   ADDR_WIDTH     - byte address width, equal to DATA_WIDTH since indirect
//                    pointers are full data words
//   TIMEOUT_CYCLES - wait cycles allowed per memory access; 0 disables
//
// Ports:
//   clk   - system clock, everything changes on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - mem_access_seq_if slave modport (request, response, memory)
// ---------------------------------------------------------------------------
module mem_access_seq #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_seq_if.slave bus
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);

    // Counter is sized so it can hold TIMEOUT_CYCLES-1, the last legal
    // wait count; one extra cycle without mem_resp means a timeout.
    localparam int              CW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        PTR_RD,
        ACCESS,
        RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic                    r_write;
    logic                    r_byte;
    logic                    r_sext;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_error;
    logic [CW-1:0]           r_count;

    logic [LB-1:0]           w_lane;
    logic [ADDR_WIDTH-1:0]   w_alignedAddr;
    logic [7:0]              w_laneByte;
    logic [DATA_WIDTH-1:0]   w_loadValue;
    logic                    w_timeout;
    logic                    w_enterMem;

    logic                    w_reqReady;
    logic                    w_rspValid;
    logic [DATA_WIDTH-1:0]   w_rspRdata;
    logic                    w_rspError;
    logic                    w_memRead;
    logic                    w_memWrite;
    logic [NB-1:0]           w_memBe;
    logic [ADDR_WIDTH-1:0]   w_memAddr;
    logic [DATA_WIDTH-1:0]   w_memWdata;

    // r_addr holds the pointer address while in PTR_RD and is overwritten
    // with the fetched effective address, so one aligned view serves both
    // memory phases.
    assign w_lane        = r_addr[LB-1:0];
    assign w_alignedAddr = {r_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};

    // Pick the byte addressed by the lane bits out of the returned word.
    always_comb begin
        w_laneByte = bus.mem_rdata[7:0];
        for (int i = 0; i < NB; i++) begin
            if (w_lane == LB'(i)) begin
                w_laneByte = bus.mem_rdata[i*8 +: 8];
            end
        end
    end

    // Byte loads are widened with either sign or zero fill; word loads pass
    // straight through.
    assign w_loadValue = r_byte
        ? {{(DATA_WIDTH-8){r_sext & w_laneByte[7]}}, w_laneByte}
        : bus.mem_rdata;

    // A timeout fires on the last allowed wait cycle only if memory has not
    // answered in that same cycle, so a late mem_resp still completes.
    assign w_timeout = TO_EN && !bus.mem_resp && (r_count == TO_LAST);

    // Any transition into a memory phase restarts the wait counter.
    assign w_enterMem = (w_nextState != r_state) &&
                        ((w_nextState == PTR_RD) || (w_nextState == ACCESS));

    // State register. Reset drops straight to IDLE, abandoning any
    // in-flight transaction without producing a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. Everything the memory sees comes from
    // the state and latched registers, so strobes, address and data stay
    // stable for the whole wait period and drop as soon as RESP is entered.
    always_comb begin
        w_nextState = r_state;
        w_reqReady  = 1'b0;
        w_rspValid  = 1'b0;
        w_rspRdata  = '0;
        w_rspError  = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_memBe     = '1;
        w_memAddr   = '0;
        w_memWdata  = '0;

        unique case (r_state)
            IDLE: begin
                w_reqReady = 1'b1;
                if (bus.req_valid) begin
                    w_nextState = bus.req_indirect ? PTR_RD : ACCESS;
                end
            end

            PTR_RD: begin
                w_memRead = 1'b1;
                w_memAddr = w_alignedAddr;
                if (bus.mem_resp) begin
                    w_nextState = ACCESS;
                end else if (w_timeout) begin
                    w_nextState = RESP;
                end
            end

            ACCESS: begin
                w_memAddr = w_alignedAddr;
                if (r_write) begin
                    w_memWrite = 1'b1;
                    if (r_byte) begin
                        w_memWdata = {NB{r_wdata[7:0]}};
                        w_memBe    = NB'(1) << w_lane;
                    end else begin
                        w_memWdata = r_wdata;
                    end
                end else begin
                    w_memRead = 1'b1;
                end
                if (bus.mem_resp || w_timeout) begin
                    w_nextState = RESP;
                end
            end

            RESP: begin
                w_rspValid  = 1'b1;
                w_rspRdata  = r_result;
                w_rspError  = r_error;
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request fields are captured on acceptance; the effective address is
    // replaced by the fetched pointer, and the result/error pair is captured
    // when the access completes or times out. Stores always report zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_sext   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_byte  <= bus.req_byte;
                        r_sext  <= bus.req_sext;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                    end
                end

                PTR_RD: begin
                    if (bus.mem_resp) begin
                        r_addr <= ADDR_WIDTH'(bus.mem_rdata);
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (bus.mem_resp) begin
                        r_result <= r_write ? '0 : w_loadValue;
                        r_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // Wait-cycle counter: cleared on entry to a memory phase and advanced
    // on every cycle memory keeps us waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_enterMem) begin
            r_count <= '0;
        end else if (TO_EN && ((r_state == PTR_RD) || (r_state == ACCESS)) && !bus.mem_resp) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.req_ready       = w_reqReady;
    assign bus.busy            = (r_state != IDLE);
    assign bus.rsp_valid       = w_rspValid;
    assign bus.rsp_rdata       = w_rspRdata;
    assign bus.rsp_error       = w_rspError;
    assign bus.mem_read        = w_memRead;
    assign bus.mem_write       = w_memWrite;
    assign bus.mem_byte_enable = w_memBe;
    assign bus.mem_address     = w_memAddr;
    assign bus.mem_wdata       = w_memWdata;

endmodule

// File: tb/tb_mem_access_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_access_seq
//
// Purpose:
//   Self-checking bench for mem_access_seq. A 16-bit instance carries most
//   of the traffic, a 32-bit instance covers the wider lane decode. Both use
//   a wait-state limit of 4. Expected responses are queued when a request is
//   driven and popped by a monitor whenever rsp_valid pulses.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_access_seq;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;

    int testCount    = 0;
    int failCount    = 0;
    int acceptCount16 = 0;

    logic [16:0] q16[$];
    logic [32:0] q32[$];
    logic [16:0] exp16;
    logic [32:0] exp32;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    mem_access_seq_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus16 ();
    mem_access_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();

    mem_access_seq #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (16),
        .TIMEOUT_CYCLES(TO)
    ) u_dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus16.slave)
    );

    mem_access_seq #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) u_dut32 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus32.slave)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Response monitor, sampling 1 time unit after the falling edge so both
    // the driven inputs and the registered outputs are settled. It also
    // counts accepted requests on the 16-bit instance.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus16.req_valid && bus16.req_ready) begin
            acceptCount16++;
        end
        if (bus16.rsp_valid) begin
            if (q16.size() == 0) begin
                checkOutput("rsp16Unexpected", 32'd1, 32'd0);
            end else begin
                exp16 = q16.pop_front();
                checkOutput("rsp16Data",  {16'h0, bus16.rsp_rdata}, {16'h0, exp16[15:0]});
                checkOutput("rsp16Error", {31'h0, bus16.rsp_error}, {31'h0, exp16[16]});
            end
        end
        if (bus32.rsp_valid) begin
            if (q32.size() == 0) begin
                checkOutput("rsp32Unexpected", 32'd1, 32'd0);
            end else begin
                exp32 = q32.pop_front();
                checkOutput("rsp32Data",  bus32.rsp_rdata, exp32[31:0]);
                checkOutput("rsp32Error", {31'h0, bus32.rsp_error}, {31'h0, exp32[32]});
            end
        end
    end

    // Behaves as the memory for one phase on the 16-bit instance: checks the
    // strobes every cycle and answers after 'waits' wait cycles, or never
    // answers (for 'waits' cycles) when respond is 0.
    task automatic memPhase(input string tag, input logic expRead, input logic expWrite,
                            input logic [15:0] expAddr, input logic [1:0] expBe,
                            input logic [15:0] expWdata, input logic [15:0] rdata,
                            input int waits, input bit respond);
        int cycles;
        cycles = respond ? waits + 1 : waits;
        for (int i = 0; i < cycles; i++) begin
            checkOutput({tag, "Read"},  {31'h0, bus16.mem_read},        {31'h0, expRead});
            checkOutput({tag, "Write"}, {31'h0, bus16.mem_write},       {31'h0, expWrite});
            checkOutput({tag, "Addr"},  {16'h0, bus16.mem_address},     {16'h0, expAddr});
            checkOutput({tag, "Be"},    {30'h0, bus16.mem_byte_enable}, {30'h0, expBe});
            checkOutput({tag, "Wdata"}, {16'h0, bus16.mem_wdata},       {16'h0, expWdata});
            if (respond && i == waits) begin
                bus16.mem_resp  = 1'b1;
                bus16.mem_rdata = rdata;
            end
            @(negedge clk);
            bus16.mem_resp = 1'b0;
        end
    endtask

    // Runs one full transaction on the 16-bit instance, deriving the
    // expected memory-side values from the request and queueing the
    // expected response.
    task automatic applyStimulus(input string tag, input bit write, input bit isByte,
                                 input bit sext, input bit indirect,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] ptrVal, input logic [15:0] rdVal,
                                 input int waits, input bit timeoutHit,
                                 input logic [15:0] expRdata);
        logic [15:0] eff;
        logic [15:0] aligned;
        logic [1:0]  be;
        logic [15:0] wexp;

        checkOutput({tag, "Ready"}, {31'h0, bus16.req_ready}, 32'd1);
        bus16.req_write    = write;
        bus16.req_byte     = isByte;
        bus16.req_sext     = sext;
        bus16.req_indirect = indirect;
        bus16.req_addr     = addr;
        bus16.req_wdata    = wdata;
        bus16.req_valid    = 1'b1;
        q16.push_back({timeoutHit, expRdata});
        @(negedge clk);
        bus16.req_valid = 1'b0;
        checkOutput({tag, "Busy"}, {31'h0, bus16.busy}, 32'd1);

        if (indirect) begin
            memPhase({tag, "Ptr"}, 1'b1, 1'b0, addr & 16'hFFFE, 2'b11, 16'h0000, ptrVal, 0, 1'b1);
        end

        eff     = indirect ? ptrVal : addr;
        aligned = eff & 16'hFFFE;
        be      = (write && isByte) ? (eff[0] ? 2'b10 : 2'b01) : 2'b11;
        wexp    = !write ? 16'h0000 : (isByte ? {wdata[7:0], wdata[7:0]} : wdata);

        memPhase({tag, "Acc"}, !write, write, aligned, be, wexp, rdVal,
                 timeoutHit ? TO : waits, !timeoutHit);

        checkOutput({tag, "RspValid"},  {31'h0, bus16.rsp_valid}, 32'd1);
        checkOutput({tag, "RspStrobe"}, {30'h0, bus16.mem_read, bus16.mem_write}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "RspPulse"},  {31'h0, bus16.rsp_valid}, 32'd0);
        checkOutput({tag, "IdleReady"}, {31'h0, bus16.req_ready}, 32'd1);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int startAcc;

        rst_n = 1'b0;
        bus16.req_valid = 1'b0; bus16.req_write = 1'b0; bus16.req_byte = 1'b0;
        bus16.req_sext = 1'b0;  bus16.req_indirect = 1'b0; bus16.req_addr = '0;
        bus16.req_wdata = '0;   bus16.mem_rdata = '0; bus16.mem_resp = 1'b0;
        bus32.req_valid = 1'b0; bus32.req_write = 1'b0; bus32.req_byte = 1'b0;
        bus32.req_sext = 1'b0;  bus32.req_indirect = 1'b0; bus32.req_addr = '0;
        bus32.req_wdata = '0;   bus32.mem_rdata = '0; bus32.mem_resp = 1'b0;

        // Reset values
        @(negedge clk);
        checkOutput("rstReady",  {31'h0, bus16.req_ready},       32'd1);
        checkOutput("rstBusy",   {31'h0, bus16.busy},            32'd0);
        checkOutput("rstRsp",    {31'h0, bus16.rsp_valid},       32'd0);
        checkOutput("rstErr",    {31'h0, bus16.rsp_error},       32'd0);
        checkOutput("rstRdata",  {16'h0, bus16.rsp_rdata},       32'd0);
        checkOutput("rstStrobe", {30'h0, bus16.mem_read, bus16.mem_write}, 32'd0);
        checkOutput("rstBe",     {30'h0, bus16.mem_byte_enable}, 32'h3);
        checkOutput("rstAddr",   {16'h0, bus16.mem_address},     32'd0);
        checkOutput("rstWdata",  {16'h0, bus16.mem_wdata},       32'd0);
        checkOutput("rstBe32",   {28'h0, bus32.mem_byte_enable}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main traffic on the 16-bit instance
        applyStimulus("wordLd",    0, 0, 0, 0, 16'h1235, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'hBEEF);
        applyStimulus("byteLdSx",  0, 1, 1, 0, 16'h0101, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 16'hFF80);
        applyStimulus("byteLdZx",  0, 1, 0, 0, 16'h0101, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 16'h0080);
        applyStimulus("byteLdL0",  0, 1, 1, 0, 16'h0100, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 16'hFFFF);
        applyStimulus("byteSt",    1, 1, 0, 0, 16'h2001, 16'h12AB, 16'h0000, 16'h0000, 3, 0, 16'h0000);
        applyStimulus("wordSt",    1, 0, 0, 0, 16'h0A07, 16'hC0DE, 16'h0000, 16'hFFFF, 2, 0, 16'h0000);
        applyStimulus("sti",       1, 0, 0, 1, 16'h0040, 16'h5A5A, 16'h3000, 16'h0000, 0, 0, 16'h0000);
        applyStimulus("ldi",       0, 1, 0, 1, 16'h0041, 16'h0000, 16'h0503, 16'h7F00, 1, 0, 16'h007F);
        applyStimulus("timeout",   0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000);
        applyStimulus("limitResp", 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1111, 3, 0, 16'h1111);

        // Reset during a wait cycle: no response may ever follow
        bus16.req_write = 1'b0; bus16.req_byte = 1'b0; bus16.req_indirect = 1'b0;
        bus16.req_addr  = 16'h0500;
        bus16.req_valid = 1'b1;
        @(negedge clk);
        bus16.req_valid = 1'b0;
        checkOutput("midRstReadBefore", {31'h0, bus16.mem_read}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midRstRead",  {31'h0, bus16.mem_read},  32'd0);
        checkOutput("midRstWrite", {31'h0, bus16.mem_write}, 32'd0);
        checkOutput("midRstReady", {31'h0, bus16.req_ready}, 32'd1);
        checkOutput("midRstBusy",  {31'h0, bus16.busy},      32'd0);
        repeat (6) @(negedge clk);

        // Back-to-back requests with req_valid held high
        startAcc = acceptCount16;
        q16.push_back({1'b0, 16'h4321});
        q16.push_back({1'b0, 16'h4321});
        bus16.req_addr  = 16'h0600;
        bus16.req_valid = 1'b1;
        for (int t = 0; t < 2; t++) begin
            if (t > 0) begin
                @(negedge clk);
                checkOutput("b2bIdleReady", {31'h0, bus16.req_ready}, 32'd1);
            end
            @(negedge clk);
            checkOutput("b2bBusyReady", {31'h0, bus16.req_ready}, 32'd0);
            checkOutput("b2bRead",      {31'h0, bus16.mem_read},  32'd1);
            bus16.mem_resp  = 1'b1;
            bus16.mem_rdata = 16'h4321;
            @(negedge clk);
            bus16.mem_resp = 1'b0;
            checkOutput("b2bRspReady", {31'h0, bus16.req_ready}, 32'd0);
            checkOutput("b2bRsp",      {31'h0, bus16.rsp_valid}, 32'd1);
            if (t == 1) begin
                bus16.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("b2bAccepts", acceptCount16 - startAcc, 32'd2);

        // 32-bit instance: lane 3 byte store and byte load
        bus32.req_write = 1'b1; bus32.req_byte = 1'b1; bus32.req_sext = 1'b0;
        bus32.req_indirect = 1'b0;
        bus32.req_addr  = 32'h0000_0103;
        bus32.req_wdata = 32'h0000_00C3;
        bus32.req_valid = 1'b1;
        q32.push_back({1'b0, 32'h0000_0000});
        @(negedge clk);
        bus32.req_valid = 1'b0;
        checkOutput("w32StWrite", {31'h0, bus32.mem_write},       32'd1);
        checkOutput("w32StBe",    {28'h0, bus32.mem_byte_enable}, 32'h8);
        checkOutput("w32StWdata", bus32.mem_wdata,                32'hC3C3_C3C3);
        checkOutput("w32StAddr",  bus32.mem_address,              32'h0000_0100);
        bus32.mem_resp = 1'b1;
        @(negedge clk);
        bus32.mem_resp = 1'b0;
        checkOutput("w32StRsp",   {31'h0, bus32.rsp_valid},       32'd1);
        @(negedge clk);

        bus32.req_write = 1'b0; bus32.req_sext = 1'b1;
        bus32.req_addr  = 32'h0000_0007;
        bus32.req_valid = 1'b1;
        q32.push_back({1'b0, 32'hFFFF_FF9A});
        @(negedge clk);
        bus32.req_valid = 1'b0;
        checkOutput("w32LdRead",  {31'h0, bus32.mem_read}, 32'd1);
        checkOutput("w32LdAddr",  bus32.mem_address,       32'h0000_0004);
        bus32.mem_resp  = 1'b1;
        bus32.mem_rdata = 32'h9A00_0000;
        @(negedge clk);
        bus32.mem_resp = 1'b0;
        checkOutput("w32LdRsp",   {31'h0, bus32.rsp_valid}, 32'd1);
        @(negedge clk);
        @(negedge clk);

        // Every queued response must have been seen
        checkOutput("sb16Empty", q16.size(), 32'd0);
        checkOutput("sb32Empty", q32.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory-access sequencer that takes memory transactions out of the multicycle CPU control FSM.
- The control FSM issues one request: read or write, word or byte, direct or indirect.
- This block drives the memory strobes, byte lanes and alignment, the indirect pointer fetch, and a wait-state timeout. It returns one response per request.
- It sits between cpu_control and the memory port, and generalises the LDR/STR/LDB/STB/LDI/STI memory states to any data width.

Parameters:
- DATA_WIDTH, 16, memory/data word width in bits; must be a multiple of 8 and at least 16.
- ADDR_WIDTH, 16, byte address width; must equal DATA_WIDTH (indirect pointers are full data words).
- TIMEOUT_CYCLES, 255, maximum wait cycles per memory access before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = full word.
- req_sext  in  1  byte loads: 1 = sign-extend, 0 = zero-extend.
- req_indirect  in  1  1 = req_addr holds pointer to the effective address.
- req_addr  in  ADDR_WIDTH  byte address (or pointer address).
- req_wdata  in  DATA_WIDTH  store data; byte stores use bits [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- rsp_error  out  1  qualifies rsp_valid: access timed out.
- busy  out  1  request in flight.
- mem_address  out  ADDR_WIDTH  memory address, word aligned.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byte_enable  out  DATA_WIDTH/8  write lane mask.
- mem_resp  in  1  memory completion.

Behaviour:
- Derived constants: NB = DATA_WIDTH/8; LB = clog2(NB). "Lane" = addr[LB-1:0].
- Reset (rst_n=0 at posedge):
  - State goes to IDLE and the timeout counter clears.
  - After that edge: req_ready=1, busy=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_byte_enable=all ones, mem_address=0, mem_wdata=0.
  - Reset mid-operation abandons the transaction. No response is issued. Strobes drop after the reset edge.
- States: IDLE, PTR_RD, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Go to PTR_RD if req_indirect, else ACCESS.
  - req_ready=0 in every other state.
- PTR_RD:
  - mem_read=1, mem_address = latched addr with lane bits zeroed.
  - On mem_resp, latch mem_rdata as the effective address and go to ACCESS.
- ACCESS, word access:
  - mem_address = effective addr with lane bits zeroed. Word accesses ignore lane bits.
  - Load: mem_read=1.
  - Store: mem_write=1, mem_byte_enable = all ones, mem_wdata = wdata.
- ACCESS, byte access:
  - Load: rdata = mem_rdata byte at lane, extended per req_sext.
  - Store: mem_wdata = wdata[7:0] replicated in every lane; mem_byte_enable is one-hot at lane.
- On mem_resp in ACCESS, latch the result and go to RESP.
- Strobes and mem_address are combinational from state and latched registers. They are held stable until mem_resp.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - No backpressure on the response.
  - A new request is accepted at the earliest in the cycle after RESP.
- Timeout:
  - Counter clears on entering PTR_RD/ACCESS and increments each cycle without mem_resp.
  - If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with no mem_resp, go to RESP with rsp_error=1 and rsp_rdata=0.
  - Strobes are deasserted from the RESP cycle.
  - mem_resp arriving in the same cycle as the limit wins: normal completion.
- busy = (state != IDLE).
- Latency, zero-wait memory (accept at cycle 0):
  - Direct: strobe in cycle 1, rsp_valid in cycle 2.
  - Indirect: pointer read in cycle 1, access in cycle 2, rsp_valid in cycle 3.
- Each wait cycle adds one cycle of latency.

Test Plan:
- Direct word load, DATA_WIDTH=16: addr=0x1235, mem_resp in first cycle, mem_rdata=0xBEEF -> mem_address=0x1234, mem_read for 1 cycle, rsp_valid at cycle 2 with rsp_rdata=0xBEEF, rsp_error=0.
- Byte load, sext: addr=0x0101, mem_rdata=0x80FF, req_sext=1 -> rsp_rdata=0xFF80. Repeat with req_sext=0 -> 0x0080. Repeat with addr=0x0100, sext=1 -> 0xFFFF.
- Byte store: addr=0x2001, wdata=0x12AB, 3 wait cycles -> mem_write held 4 cycles, mem_wdata=0xABAB, mem_byte_enable=2'b10, address 0x2000, rsp_valid one cycle after mem_resp, rsp_rdata=0.
- Indirect word store (STI): addr=0x0040, pointer read returns 0x3000, wdata=0x5A5A -> read at 0x0040, then write at 0x3000 with mask 2'b11, one rsp_valid.
- Timeout with TIMEOUT_CYCLES=4: mem_resp never asserted -> mem_read high 4 cycles, then rsp_valid=1 and rsp_error=1, then IDLE with req_ready=1. Repeat with mem_resp in the 4th cycle -> normal response, no error.
- Reset mid-access: rst_n=0 during a wait cycle -> after the edge, strobes=0, req_ready=1, and no rsp_valid ever appears. Then back-to-back requests with req_valid held high -> one accept per transaction, req_ready low while busy, and DATA_WIDTH=32 variant checks lane 3 mask 4'b1000.
